// File: rtl/dmem_arb_pkg.sv
// Shared widths, limits and pointer sizing for the data-memory arbiter.
// No logic; constants and a sizing helper only.
// Not applicable: no flow control lives here.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 1001;
    localparam int NUM_CORES_MAX = 8;

    // A single-core build still needs a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin priority picker: first eligible requester at or after rr_ptr.
// Latency: purely combinational.
// Backpressure: none; a zero eligible vector yields no grant.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] win,
    output logic          any_gnt
);

    int idx;

    // Scan from the far end back to rr_ptr so the last hit is the nearest one.
    always_comb begin
        gnt     = '0;
        win     = '0;
        any_gnt = |elig;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (elig[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                win      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
// Latency: ack/rdata/err one cycle after grant; worst-case wait NUM_CORES cycles.
// Backpressure: cores hold req until their ack pulse; at most one access per cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          core_err,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_write,
    output logic                          mem_read,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int               PW    = ptr_w(NUM_CORES);
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        win;
    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] gnt;
    logic                 any_gnt;
    logic [ADDR_W-1:0]    sel_addr;
    logic [ADDR_W-1:0]    last_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [DATA_W-1:0]    last_wdata;
    logic                 sel_we;
    logic                 in_range;

    // A core in its ack cycle still shows the request just served.
    assign elig = core_req & ~core_ack;

    rr_pick #(
        .N  (NUM_CORES),
        .PW (PW)
    ) u_rr_pick (
        .elig    (elig),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .win     (win),
        .any_gnt (any_gnt)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt[i]) begin
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
                sel_we    = core_we[i];
            end
        end
    end

    assign in_range = sel_addr < DEPTH;

    // Memory strobes are gated by reset so an in-flight write cannot commit.
    assign mem_addr  = !rst_n ? '0 : (any_gnt ? sel_addr  : last_addr);
    assign mem_wdata = !rst_n ? '0 : (any_gnt ? sel_wdata : last_wdata);
    assign mem_read  = rst_n & any_gnt & ~sel_we;
    assign mem_write = rst_n & any_gnt & sel_we & in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ack   <= '0;
            core_rdata <= '0;
            core_err   <= 1'b0;
            rr_ptr     <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            core_ack   <= gnt;
            core_err   <= any_gnt & ~in_range;
            core_rdata <= (any_gnt & ~sel_we & in_range) ? mem_rdata : '0;
            if (any_gnt) begin
                rr_ptr     <= (win == PW'(NUM_CORES - 1)) ? '0 : win + PW'(1);
                last_addr  <= sel_addr;
                last_wdata <= sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and an ack scoreboard.
module tb_dmem_arbiter;

    localparam int NC = 4;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } creq_t;

    typedef struct packed {
        logic [2:0]  core;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NC-1:0]   core_req = '0;
    logic [NC-1:0]   core_we = '0;
    logic [NC*16-1:0] core_addr = '0;
    logic [NC*16-1:0] core_wdata = '0;
    logic [NC-1:0]   core_ack;
    logic [15:0]     core_rdata;
    logic            core_err;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_wdata;
    logic            mem_write;
    logic            mem_read;
    logic [15:0]     mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    creq_t cq [NC][$];
    exp_t  exp_q [$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_DEPTH (1001)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .core_err   (core_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: combinational read, write on posedge; mem[i] = 3*i except a few seeds.
    logic [15:0] mem [0:1000];
    logic        mem_init = 1'b0;
    int          wr_cnt = 0;

    assign mem_rdata = (mem_addr < 16'd1001) ? mem[mem_addr] : 16'h0000;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1001; i++) mem[i] <= 16'(i * 3);
            mem[0]   <= 16'd4;
            mem[100] <= 16'd1;
            mem[101] <= 16'd8;
            mem[102] <= 16'd8;
            mem[103] <= 16'd1;
            mem_init <= 1'b1;
        end else if (mem_write) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_addr < 16'd1001) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int c, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        creq_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        cq[c].push_back(r);
    endtask

    task automatic expect_ack(input int c, input logic [15:0] rdata, input logic err);
        exp_t e;
        e.core = 3'(c); e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            if (cq[i].size() > 0) begin
                core_req[i]             = 1'b1;
                core_we[i]              = cq[i][0].we;
                core_addr[i*16 +: 16]   = cq[i][0].addr;
                core_wdata[i*16 +: 16]  = cq[i][0].wdata;
            end else begin
                core_req[i] = 1'b0;
            end
        end
    endtask

    // A core retires its front request when it sees its ack, then presents the next one.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (core_ack[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        end
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < NC; i++) if (cq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input string name, input int budget, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while ((pending() || core_ack != '0) && steps < budget);
        if (pending() || core_ack != '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, steps);
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic flush();
        for (int i = 0; i < NC; i++) cq[i].delete();
        exp_q.delete();
        core_req = '0;
    endtask

    task automatic do_reset();
        flush();
        rst_n = 1'b0;
        #1;
        check("rst_ack",   core_ack,   0);
        check("rst_rdata", core_rdata, 0);
        check("rst_err",   core_err,   0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read",  mem_read,  0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_rr_ptr", dut.rr_ptr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int steps;
        int w0;
        fork
            // Monitor: every ack must match the head of the scoreboard.
            forever begin
                @(negedge clk);
                if (rst_n && core_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ack: got ack 0x%0h, expected none", core_ack);
                    end else begin
                        exp_t e;
                        logic [NC-1:0] ev;
                        e  = exp_q.pop_front();
                        ev = NC'(1) << e.core;
                        check("ack_vec",  core_ack,   ev);
                        check("ack_rdata", core_rdata, e.rdata);
                        check("ack_err",  core_err,   e.err);
                    end
                end
            end
            begin
                #2;
                do_reset();

                // Reset mid-stream: core0 write acked, core2 write in its grant cycle.
                add(0, 1'b1, 16'd500, 16'h0055);
                add(2, 1'b1, 16'd501, 16'h0066);
                expect_ack(0, 16'h0, 1'b0);
                drive();
                step();
                check("t1_core2_write_granted", mem_write, 1);
                #1;
                rst_n = 1'b0;
                #1;
                check("t1_midrst_ack", core_ack, 0);
                check("t1_midrst_mem_write", mem_write, 0);
                check("t1_midrst_rr_ptr", dut.rr_ptr, 0);
                flush();
                repeat (2) @(posedge clk);
                check("t1_mem500_written", mem[500], 16'h0055);
                check("t1_mem501_untouched", mem[501], 16'd1503);
                @(negedge clk);
                rst_n = 1'b1;
                add(1, 1'b0, 16'd0, 16'h0);
                expect_ack(1, 16'd4, 1'b0);
                drive();
                run("t1_read0", 10, steps);
                check("t1_latency", steps, 2);

                // Full load round robin from rr_ptr = 0.
                do_reset();
                add(0, 1'b0, 16'd100, 16'h0);
                add(1, 1'b0, 16'd101, 16'h0);
                add(2, 1'b0, 16'd102, 16'h0);
                add(3, 1'b0, 16'd103, 16'h0);
                add(0, 1'b0, 16'd100, 16'h0);
                expect_ack(0, 16'd1, 1'b0);
                expect_ack(1, 16'd8, 1'b0);
                expect_ack(2, 16'd8, 1'b0);
                expect_ack(3, 16'd1, 1'b0);
                expect_ack(0, 16'd1, 1'b0);
                drive();
                run("t2_rr", 20, steps);
                check("t2_cycles", steps, 6);
                check("t2_rr_ptr", dut.rr_ptr, 1);

                // Write then read of the same address in the following grant.
                add(0, 1'b1, 16'd999, 16'd7);
                expect_ack(0, 16'h0, 1'b0);
                drive();
                step();
                add(2, 1'b0, 16'd999, 16'h0);
                expect_ack(2, 16'd7, 1'b0);
                drive();
                run("t3_wr_rd", 10, steps);
                check("t3_rr_ptr", dut.rr_ptr, 3);

                // Out-of-range write and read, then the last valid address.
                w0 = wr_cnt;
                add(3, 1'b1, 16'd1500, 16'hbeef);
                add(1, 1'b0, 16'd2000, 16'h0);
                add(1, 1'b0, 16'd1000, 16'h0);
                expect_ack(3, 16'h0, 1'b1);
                expect_ack(1, 16'h0, 1'b1);
                expect_ack(1, 16'd3000, 1'b0);
                drive();
                run("t4_range", 20, steps);
                check("t4_no_write", wr_cnt, w0);
                check("t4_mem499", mem[499], 16'd1497);

                // Wrap: bring rr_ptr to 3, then cores 3 and 0 compete.
                add(2, 1'b0, 16'd102, 16'h0);
                expect_ack(2, 16'd8, 1'b0);
                drive();
                run("t5_setup", 10, steps);
                check("t5_rr_ptr_before", dut.rr_ptr, 3);
                add(3, 1'b0, 16'd103, 16'h0);
                add(0, 1'b0, 16'd101, 16'h0);
                expect_ack(3, 16'd1, 1'b0);
                expect_ack(0, 16'd8, 1'b0);
                drive();
                run("t5_wrap", 10, steps);
                check("t5_rr_ptr_after", dut.rr_ptr, 1);

                // Re-request in the ack cycle must not jump ahead of a waiting core.
                add(1, 1'b0, 16'd100, 16'h0);
                add(1, 1'b0, 16'd103, 16'h0);
                add(2, 1'b0, 16'd101, 16'h0);
                expect_ack(1, 16'd1, 1'b0);
                expect_ack(2, 16'd8, 1'b0);
                expect_ack(1, 16'd1, 1'b0);
                drive();
                run("t6_rereq", 10, steps);
                check("t6_rr_ptr", dut.rr_ptr, 2);

                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        join_any
    end

endmodule
